ip_tx_arb: RTL and testbench

- Round-robin arbiter that shares the single IP transmit input of the IPv4/ARP stack (s_ip_* header + payload stream) among S_COUNT requesters, e.g. RTPS writer, SPDP announcer, ICMP responder.
- Grants one requester per frame and holds the grant from header through payload tlast.
- Payload stall watchdog: a stalled requester is aborted with an error-marked tlast, so the shared path can never lock up.

---
 rtl/ip_tx_arb_pkg.sv | 33 +++
 rtl/ip_tx_arb_rr_arbiter.sv | 30 +++
 rtl/ip_tx_arb.sv | 184 ++++++++++++++++++
 tb/tb_ip_tx_arb.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_tx_arb_pkg.sv
// Shared constants and types for the IP transmit arbiter.
package ip_tx_arb_pkg;

    localparam int IP_HDR_W = 104;

    // Packed header layout, MSB first:
    // {dscp, ecn, length, ttl, protocol, source_ip, dest_ip}
    localparam int IP_HDR_DSCP_OFF     = 98;
    localparam int IP_HDR_DSCP_W       = 6;
    localparam int IP_HDR_ECN_OFF      = 96;
    localparam int IP_HDR_ECN_W        = 2;
    localparam int IP_HDR_LENGTH_OFF   = 80;
    localparam int IP_HDR_LENGTH_W     = 16;
    localparam int IP_HDR_TTL_OFF      = 72;
    localparam int IP_HDR_TTL_W        = 8;
    localparam int IP_HDR_PROTOCOL_OFF = 64;
    localparam int IP_HDR_PROTOCOL_W   = 8;
    localparam int IP_HDR_SRC_OFF      = 32;
    localparam int IP_HDR_SRC_W        = 32;
    localparam int IP_HDR_DST_OFF      = 0;
    localparam int IP_HDR_DST_W        = 32;

    localparam int GRANT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_ABORT   = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

endpackage

// File: rtl/ip_tx_arb_rr_arbiter.sv
// Combinational round-robin picker: first request at or after the pointer,
// wrapping modulo N. Reusable at any sharing point.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan N candidates starting at the pointer; the first hit wins.
    always_comb begin
        int c;
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_o = '0;
        idx_o   = '0;
        c       = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr_i) + k) % N;
            if (grant_o == '0 && req_i[c]) begin
                grant_o[c] = 1'b1;
                idx_o      = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/ip_tx_arb.sv
// Round-robin arbiter sharing one IP transmit port (header + payload stream)
// among S_COUNT requesters, with a payload stall watchdog.
module ip_tx_arb
    import ip_tx_arb_pkg::*;
#(
    parameter int S_COUNT        = 3,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [S_COUNT-1:0]          s_ip_hdr_valid,
    output logic [S_COUNT-1:0]          s_ip_hdr_ready,
    input  logic [S_COUNT*IP_HDR_W-1:0] s_ip_hdr,
    input  logic [S_COUNT*8-1:0]        s_ip_payload_axis_tdata,
    input  logic [S_COUNT-1:0]          s_ip_payload_axis_tvalid,
    input  logic [S_COUNT-1:0]          s_ip_payload_axis_tlast,
    input  logic [S_COUNT-1:0]          s_ip_payload_axis_tuser,
    output logic [S_COUNT-1:0]          s_ip_payload_axis_tready,
    output logic                        m_ip_hdr_valid,
    input  logic                        m_ip_hdr_ready,
    output logic [5:0]                  m_ip_dscp,
    output logic [1:0]                  m_ip_ecn,
    output logic [15:0]                 m_ip_length,
    output logic [7:0]                  m_ip_ttl,
    output logic [7:0]                  m_ip_protocol,
    output logic [31:0]                 m_ip_source_ip,
    output logic [31:0]                 m_ip_dest_ip,
    output logic [7:0]                  m_ip_payload_axis_tdata,
    output logic                        m_ip_payload_axis_tvalid,
    output logic                        m_ip_payload_axis_tlast,
    output logic                        m_ip_payload_axis_tuser,
    input  logic                        m_ip_payload_axis_tready,
    output logic [GRANT_W-1:0]          grant_idx,
    output logic                        busy,
    output logic                        abort_pulse
);

    state_t               state_q, state_d;
    logic [GRANT_W-1:0]   ptr_q, ptr_d;
    logic [GRANT_W-1:0]   grant_q, grant_d;
    logic [CNT_WIDTH-1:0] wd_q, wd_d;
    logic                 abort_q, abort_d;

    logic [S_COUNT-1:0]   arb_grant;
    logic [GRANT_W-1:0]   arb_idx;
    logic [S_COUNT-1:0]   grant_oh;
    logic [GRANT_W-1:0]   ptr_next;
    logic [IP_HDR_W-1:0]  sel_hdr, hdr_out;
    logic                 sel_hdr_valid, sel_tvalid, sel_tlast, sel_tuser;
    logic [7:0]           sel_tdata;

    rr_arbiter #(.N(S_COUNT), .IDX_W(GRANT_W)) u_rr (
        .req_i   (s_ip_hdr_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    // Select the granted requester's header and payload signals.
    always_comb begin
        grant_oh      = '0;
        sel_hdr       = '0;
        sel_hdr_valid = 1'b0;
        sel_tdata     = '0;
        sel_tvalid    = 1'b0;
        sel_tlast     = 1'b0;
        sel_tuser     = 1'b0;
        for (int k = 0; k < S_COUNT; k++) begin
            if (int'(grant_q) == k) begin
                grant_oh[k]   = 1'b1;
                sel_hdr       = s_ip_hdr[k*IP_HDR_W +: IP_HDR_W];
                sel_hdr_valid = s_ip_hdr_valid[k];
                sel_tdata     = s_ip_payload_axis_tdata[k*8 +: 8];
                sel_tvalid    = s_ip_payload_axis_tvalid[k];
                sel_tlast     = s_ip_payload_axis_tlast[k];
                sel_tuser     = s_ip_payload_axis_tuser[k];
            end
        end
    end

    assign ptr_next = (int'(grant_q) >= S_COUNT - 1) ? '0 : grant_q + 1'b1;

    // Next-state logic and per-state output drive.
    always_comb begin
        state_d                  = state_q;
        ptr_d                    = ptr_q;
        grant_d                  = grant_q;
        wd_d                     = wd_q;
        abort_d                  = 1'b0;
        s_ip_hdr_ready           = '0;
        s_ip_payload_axis_tready = '0;
        m_ip_hdr_valid           = 1'b0;
        m_ip_payload_axis_tdata  = '0;
        m_ip_payload_axis_tvalid = 1'b0;
        m_ip_payload_axis_tlast  = 1'b0;
        m_ip_payload_axis_tuser  = 1'b0;
        hdr_out                  = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_grant != '0) begin
                    grant_d = arb_idx;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                m_ip_hdr_valid = sel_hdr_valid;
                hdr_out        = sel_hdr;
                s_ip_hdr_ready = m_ip_hdr_ready ? grant_oh : '0;
                if (!sel_hdr_valid) begin
                    // Withdrawn request: leave the pointer where it was.
                    state_d = ST_IDLE;
                end else if (m_ip_hdr_ready) begin
                    state_d = ST_PAYLOAD;
                    ptr_d   = ptr_next;
                    wd_d    = '0;
                end
            end
            ST_PAYLOAD: begin
                m_ip_payload_axis_tdata  = sel_tdata;
                m_ip_payload_axis_tvalid = sel_tvalid;
                m_ip_payload_axis_tlast  = sel_tlast;
                m_ip_payload_axis_tuser  = sel_tuser;
                s_ip_payload_axis_tready = m_ip_payload_axis_tready ? grant_oh : '0;
                if (sel_tvalid) begin
                    // Only source idle cycles count; backpressure never does.
                    wd_d = '0;
                    if (m_ip_payload_axis_tready && sel_tlast) state_d = ST_IDLE;
                end else if (TIMEOUT_CYCLES != 0 &&
                             wd_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    // This idle cycle is the TIMEOUT_CYCLES-th in a row.
                    abort_d = 1'b1;
                    state_d = ST_ABORT;
                end else if (wd_q != '1) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_ABORT: begin
                m_ip_payload_axis_tvalid = 1'b1;
                m_ip_payload_axis_tlast  = 1'b1;
                m_ip_payload_axis_tuser  = 1'b1;
                if (m_ip_payload_axis_tready) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                s_ip_payload_axis_tready = grant_oh;
                if (sel_tvalid && sel_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign m_ip_dscp      = hdr_out[IP_HDR_DSCP_OFF     +: IP_HDR_DSCP_W];
    assign m_ip_ecn       = hdr_out[IP_HDR_ECN_OFF      +: IP_HDR_ECN_W];
    assign m_ip_length    = hdr_out[IP_HDR_LENGTH_OFF   +: IP_HDR_LENGTH_W];
    assign m_ip_ttl       = hdr_out[IP_HDR_TTL_OFF      +: IP_HDR_TTL_W];
    assign m_ip_protocol  = hdr_out[IP_HDR_PROTOCOL_OFF +: IP_HDR_PROTOCOL_W];
    assign m_ip_source_ip = hdr_out[IP_HDR_SRC_OFF      +: IP_HDR_SRC_W];
    assign m_ip_dest_ip   = hdr_out[IP_HDR_DST_OFF      +: IP_HDR_DST_W];

    assign grant_idx   = grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign abort_pulse = abort_q;

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            wd_q    <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            wd_q    <= wd_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_ip_tx_arb.sv
// Self-checking bench for ip_tx_arb: directed edge cases plus a randomized
// scoreboard run against a frame-level round-robin/watchdog model.
module tb_ip_tx_arb;

    localparam int S  = 3;
    localparam int TO = 4;
    localparam int HW = 104;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [S-1:0]    s_ip_hdr_valid;
    logic [S-1:0]    s_ip_hdr_ready;
    logic [S*HW-1:0] s_ip_hdr;
    logic [S*8-1:0]  s_tdata;
    logic [S-1:0]    s_tvalid, s_tlast, s_tuser, s_tready;
    logic            m_ip_hdr_valid, m_ip_hdr_ready;
    logic [5:0]      m_ip_dscp;
    logic [1:0]      m_ip_ecn;
    logic [15:0]     m_ip_length;
    logic [7:0]      m_ip_ttl, m_ip_protocol;
    logic [31:0]     m_ip_source_ip, m_ip_dest_ip;
    logic [7:0]      m_tdata;
    logic            m_tvalid, m_tlast, m_tuser, m_tready;
    logic [2:0]      grant_idx;
    logic            busy, abort_pulse;

    ip_tx_arb #(.S_COUNT(S), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .s_ip_hdr_valid           (s_ip_hdr_valid),
        .s_ip_hdr_ready           (s_ip_hdr_ready),
        .s_ip_hdr                 (s_ip_hdr),
        .s_ip_payload_axis_tdata  (s_tdata),
        .s_ip_payload_axis_tvalid (s_tvalid),
        .s_ip_payload_axis_tlast  (s_tlast),
        .s_ip_payload_axis_tuser  (s_tuser),
        .s_ip_payload_axis_tready (s_tready),
        .m_ip_hdr_valid           (m_ip_hdr_valid),
        .m_ip_hdr_ready           (m_ip_hdr_ready),
        .m_ip_dscp                (m_ip_dscp),
        .m_ip_ecn                 (m_ip_ecn),
        .m_ip_length              (m_ip_length),
        .m_ip_ttl                 (m_ip_ttl),
        .m_ip_protocol            (m_ip_protocol),
        .m_ip_source_ip           (m_ip_source_ip),
        .m_ip_dest_ip             (m_ip_dest_ip),
        .m_ip_payload_axis_tdata  (m_tdata),
        .m_ip_payload_axis_tvalid (m_tvalid),
        .m_ip_payload_axis_tlast  (m_tlast),
        .m_ip_payload_axis_tuser  (m_tuser),
        .m_ip_payload_axis_tready (m_tready),
        .grant_idx                (grant_idx),
        .busy                     (busy),
        .abort_pulse              (abort_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: no expected entry queued", name);
    endtask

    // Frame stimulus tables, per requester.
    logic [HW-1:0] f_hdr  [S][8];
    int            f_len  [S][8];
    logic [7:0]    f_data [S][8][16];
    logic          f_user [S][8][16];
    int            f_gap  [S][8][16];
    int            nfr    [S];

    // Scoreboard.
    logic [106:0]  exp_hdr_q [$];
    logic [9:0]    exp_beat_q[$];
    int            exp_aborts, aborts_seen;
    int            model_ptr = 0;
    bit            sb_en = 1'b0;
    logic          prev_abort = 1'b0;

    function automatic logic [106:0] hdr_seen();
        return {grant_idx, m_ip_dscp, m_ip_ecn, m_ip_length, m_ip_ttl,
                m_ip_protocol, m_ip_source_ip, m_ip_dest_ip};
    endfunction

    // Monitor: pops and compares whenever the DUT completes a handshake.
    initial begin
        logic [106:0] eh;
        logic [9:0]   eb;
        forever begin
            @(negedge clk);
            if (sb_en) begin
                if (m_ip_hdr_valid && m_ip_hdr_ready) begin
                    if (exp_hdr_q.size() == 0) fail("hdr_unexpected");
                    else begin
                        eh = exp_hdr_q.pop_front();
                        check("hdr_grant_fields", 128'(hdr_seen()), 128'(eh));
                    end
                end
                if (m_tvalid && m_tready) begin
                    if (exp_beat_q.size() == 0) fail("beat_unexpected");
                    else begin
                        eb = exp_beat_q.pop_front();
                        check("beat_data_last_user", 128'({m_tdata, m_tlast, m_tuser}), 128'(eb));
                    end
                end
                if (abort_pulse) begin
                    aborts_seen++;
                    check("abort_pulse_single", 128'(prev_abort), 128'(0));
                end
            end
            prev_abort = abort_pulse;
        end
    end

    // Reference model: the requesters of a scenario all keep a header pending
    // until their frames run out, so grant order is a plain rotation over
    // requesters with frames left; a frame is cut at the first source gap of
    // at least TO idle cycles.
    task automatic build_expected();
        int fi[S];
        int c, ab;
        bit found;
        for (int r = 0; r < S; r++) fi[r] = 0;
        forever begin
            found = 1'b0;
            c     = 0;
            for (int k = 0; k < S; k++) begin
                if (!found && fi[(model_ptr + k) % S] < nfr[(model_ptr + k) % S]) begin
                    c     = (model_ptr + k) % S;
                    found = 1'b1;
                end
            end
            if (!found) break;
            exp_hdr_q.push_back({3'(c), f_hdr[c][fi[c]]});
            ab = -1;
            for (int j = 0; j < f_len[c][fi[c]]; j++)
                if (ab < 0 && f_gap[c][fi[c]][j] >= TO) ab = j;
            if (ab < 0) begin
                for (int j = 0; j < f_len[c][fi[c]]; j++)
                    exp_beat_q.push_back({f_data[c][fi[c]][j], j == f_len[c][fi[c]] - 1,
                                          f_user[c][fi[c]][j]});
            end else begin
                for (int j = 0; j < ab; j++)
                    exp_beat_q.push_back({f_data[c][fi[c]][j], 1'b0, f_user[c][fi[c]][j]});
                exp_beat_q.push_back({8'h00, 1'b1, 1'b1});
                exp_aborts++;
            end
            fi[c]++;
            model_ptr = (c + 1) % S;
        end
    endtask

    task automatic make_frame(input int r, input int f, input int len, input int gap_mode);
        logic [127:0] rnd;
        rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
        f_hdr[r][f] = rnd[HW-1:0];
        f_len[r][f] = len;
        for (int j = 0; j < 16; j++) begin
            f_data[r][f][j] = 8'($urandom());
            f_user[r][f][j] = (gap_mode == 1) ? 1'($urandom()) : 1'b0;
            if (gap_mode == 1)
                f_gap[r][f][j] = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 2)
                                                              : $urandom_range(0, TO - 1);
            else
                f_gap[r][f][j] = 0;
        end
    endtask

    // Cycle-based requester/sink driver; mode 0 random readies,
    // 1 payload ready pattern 1,0,0,1, 2 always ready.
    task automatic run_engine(input string name, input int mode);
        int fi[S], bi[S], ph[S], gc[S];
        logic hh[S], hp[S];
        bit done;
        exp_aborts  = 0;
        aborts_seen = 0;
        build_expected();
        for (int r = 0; r < S; r++) begin
            fi[r] = 0; bi[r] = 0; gc[r] = 0;
            ph[r] = (nfr[r] > 0) ? 0 : 2;
        end
        done  = 1'b0;
        sb_en = 1'b1;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            for (int r = 0; r < S; r++) begin
                s_ip_hdr_valid[r]       = (ph[r] == 0);
                s_ip_hdr[r*HW +: HW]    = f_hdr[r][fi[r]];
                s_tvalid[r]             = (ph[r] == 1) && (gc[r] == 0);
                s_tdata[r*8 +: 8]       = f_data[r][fi[r]][bi[r]];
                s_tlast[r]              = (bi[r] == f_len[r][fi[r]] - 1);
                s_tuser[r]              = f_user[r][fi[r]][bi[r]];
            end
            case (mode)
                0:       begin m_ip_hdr_ready = 1'($urandom()); m_tready = ($urandom_range(0, 3) != 0); end
                1:       begin m_ip_hdr_ready = 1'b1; m_tready = (cyc % 4 == 0) || (cyc % 4 == 3); end
                default: begin m_ip_hdr_ready = 1'b1; m_tready = 1'b1; end
            endcase
            @(negedge clk);
            for (int r = 0; r < S; r++) begin
                hh[r] = s_ip_hdr_valid[r] && s_ip_hdr_ready[r];
                hp[r] = s_tvalid[r] && s_tready[r];
            end
            @(posedge clk);
            #1;
            for (int r = 0; r < S; r++) begin
                if (ph[r] == 0 && hh[r]) begin
                    ph[r] = 1; bi[r] = 0; gc[r] = f_gap[r][fi[r]][0];
                end else if (ph[r] == 1) begin
                    if (hp[r]) begin
                        if (bi[r] == f_len[r][fi[r]] - 1) begin
                            fi[r]++; bi[r] = 0;
                            ph[r] = (fi[r] < nfr[r]) ? 0 : 2;
                        end else begin
                            bi[r]++; gc[r] = f_gap[r][fi[r]][bi[r]];
                        end
                    end else if (gc[r] > 0) begin
                        gc[r]--;
                    end
                end
            end
            done = (ph[0] == 2) && (ph[1] == 2) && (ph[2] == 2) && !busy &&
                   exp_hdr_q.size() == 0 && exp_beat_q.size() == 0;
        end
        s_ip_hdr_valid = '0;
        s_tvalid       = '0;
        @(negedge clk);
        sb_en = 1'b0;
        check({name, "_completed"}, 128'(done), 128'(1));
        check({name, "_abort_count"}, 128'(aborts_seen), 128'(exp_aborts));
        exp_hdr_q.delete();
        exp_beat_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_frames();
        for (int r = 0; r < S; r++) nfr[r] = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        s_ip_hdr_valid = '0; s_ip_hdr = '0;
        s_tdata = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
        m_ip_hdr_ready = 1'b0; m_tready = 1'b0;
        repeat (3) tick();

        // Reset state.
        @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_grant_idx", 128'(grant_idx), 128'(0));
        check("rst_outputs", 128'({m_ip_hdr_valid, m_tvalid, m_tlast, m_tuser, abort_pulse}), 128'(0));
        tick();
        rst_n = 1'b1;

        // Header withdrawal: pointer stays at 0 and req0 wins again.
        s_ip_hdr_valid[0] = 1'b1;
        tick();
        @(negedge clk);
        check("wd_busy_hdr", 128'(busy), 128'(1));
        check("wd_grant0", 128'(grant_idx), 128'(0));
        tick();
        s_ip_hdr_valid[0] = 1'b0;
        @(negedge clk);
        check("wd_hdr_valid_follows", 128'(m_ip_hdr_valid), 128'(0));
        tick();
        @(negedge clk);
        check("wd_back_idle", 128'(busy), 128'(0));
        tick();
        s_ip_hdr_valid = 3'b011;
        tick();
        @(negedge clk);
        check("wd_regrant_req0", 128'(grant_idx), 128'(0));
        m_ip_hdr_ready = 1'b1;
        tick();
        s_ip_hdr_valid = '0;
        s_tvalid[0] = 1'b1; s_tdata[7:0] = 8'hAA; s_tlast[0] = 1'b1;
        m_tready = 1'b1;
        @(negedge clk);
        check("wd_byte", 128'({m_tvalid, m_tdata, m_tlast}), 128'({1'b1, 8'hAA, 1'b1}));
        tick();
        s_tvalid = '0; s_tlast = '0;

        // Single requester: req1, length 0x001C, dest 192.168.1.10, 8 bytes.
        s_ip_hdr_valid[1] = 1'b1;
        s_ip_hdr[HW +: HW] = {6'h0A, 2'b01, 16'h001C, 8'd64, 8'd17, 32'hC0A80105, 32'hC0A8010A};
        s_tvalid[1] = 1'b1; s_tdata[15:8] = 8'h10; s_tlast[1] = 1'b0;
        @(negedge clk);
        check("single_hdr_valid_latency0", 128'(m_ip_hdr_valid), 128'(0));
        tick();
        @(negedge clk);
        check("single_hdr_valid", 128'(m_ip_hdr_valid), 128'(1));
        check("single_hdr_fields", 128'(hdr_seen()),
              128'({3'd1, 6'h0A, 2'b01, 16'h001C, 8'd64, 8'd17, 32'hC0A80105, 32'hC0A8010A}));
        tick();
        s_ip_hdr_valid = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("single_byte", 128'({m_tvalid, m_tdata, m_tlast}),
                  128'({1'b1, 8'(8'h10 + i), i == 7}));
            tick();
            s_tdata[15:8] = 8'(8'h11 + i);
            s_tlast[1]    = (i + 1 == 7);
            if (i == 7) s_tvalid[1] = 1'b0;
        end
        @(negedge clk);
        check("single_busy_drops", 128'(busy), 128'(0));

        // Synchronous reset in the middle of a req1 payload.
        s_ip_hdr_valid[1] = 1'b1;
        s_tvalid[1] = 1'b1; s_tdata[15:8] = 8'h55; s_tlast[1] = 1'b0;
        repeat (3) tick();
        s_ip_hdr_valid = 3'b111;
        m_ip_hdr_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("midrst_busy_grant", 128'({busy, grant_idx}), 128'(0));
        check("midrst_readies", 128'({s_ip_hdr_ready, s_tready}), 128'(0));
        check("midrst_m_outputs", 128'({m_ip_hdr_valid, m_tvalid, m_tlast, m_tuser, abort_pulse}), 128'(0));
        rst_n = 1'b1;
        s_tvalid = '0;
        tick();
        @(negedge clk);
        check("midrst_first_grant_req0", 128'({m_ip_hdr_valid, grant_idx}), 128'({1'b1, 3'd0}));
        s_ip_hdr_valid = '0;
        tick();
        tick();
        model_ptr = 0;

        // All three requesters, two 4-byte frames each.
        clear_frames();
        for (int r = 0; r < S; r++) begin
            nfr[r] = 2;
            make_frame(r, 0, 4, 0);
            make_frame(r, 1, 4, 0);
        end
        run_engine("rr_all3", 2);

        // Downstream backpressure only: no abort.
        clear_frames();
        nfr[0] = 1;
        make_frame(0, 0, 6, 0);
        run_engine("backpressure", 1);

        // Source stall on req2 after 3 bytes, then a req0 frame.
        clear_frames();
        nfr[2] = 1; nfr[0] = 1;
        make_frame(2, 0, 6, 0);
        f_gap[2][0][3] = TO;
        make_frame(0, 0, 2, 0);
        run_engine("stall_abort", 2);

        // Randomized traffic with occasional stalls and random readies.
        for (int it = 0; it < 3; it++) begin
            clear_frames();
            for (int r = 0; r < S; r++) begin
                nfr[r] = $urandom_range(1, 5);
                for (int f = 0; f < nfr[r]; f++) make_frame(r, f, $urandom_range(1, 8), 1);
            end
            run_engine("random", 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
